// File: rtl/wbctrl_pkg.sv
// Shared types and default timing constants for the warm-boot sequencer.
package wbctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    WAIT  = 3'd4
  } wb_state_e;

  localparam int unsigned DEF_SLOT_W          = 4;
  localparam int unsigned DEF_NUM_SLOTS       = 4;
  localparam int unsigned DEF_HOLD_CYCLES     = 16;
  localparam int unsigned DEF_SETUP_CYCLES    = 4;
  localparam int unsigned DEF_BOOT_CYCLES     = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1024;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 256;

  // Phase counter width: it is loaded with N-1, so clog2 of the largest N suffices.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/wbctrl_pin_sync.sv
// Boot-pin synchronizer and rising-edge detector; with WBCTRL_PIN_DEBOUNCE_EN
// the synchronized level must stay high for DEBOUNCE_CYCLES before the edge fires.
module wbctrl_pin_sync
  import wbctrl_pkg::*;
`ifdef WBCTRL_PIN_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
`endif
(
  input  logic clk_i,
  input  logic rst_n,
  input  logic pin_i,
  output logic pulse_c,
  output logic pulse_next_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = pin_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef WBCTRL_PIN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Run length of the synchronized high level; saturates one past the window so it fires once.
  always_comb begin
    cnt_d = '0;
    if (sync2_q) cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pulse_c      = sync2_q && (cnt_q == CNT_W'(DEBOUNCE_CYCLES));
  assign pulse_next_c = sync1_q && sync2_q && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
`else
  logic prev_q, prev_d;

  always_comb prev_d = sync2_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign pulse_c      = sync2_q && !prev_q;
  assign pulse_next_c = sync1_q && !sync2_q;
`endif

endmodule

// File: rtl/warmboot_ctrl.sv
// Warm-boot sequencer: arbitrates pin/software requests and drives SoC reset,
// SLOT and BOOT through HOLD/SETUP/PULSE/WAIT. Option: WBCTRL_PIN_DEBOUNCE_EN.
module warmboot_ctrl
  import wbctrl_pkg::*;
#(
  parameter int unsigned SLOT_W         = DEF_SLOT_W,
  parameter int unsigned NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned BOOT_CYCLES    = DEF_BOOT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`ifdef WBCTRL_PIN_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`endif
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              pin_req_i,
  input  logic [SLOT_W-1:0] pin_slot_i,
  input  logic              sw_req_valid_i,
  input  logic [SLOT_W-1:0] sw_req_slot_i,
  output logic              sw_req_ready_o,
  input  logic              wb_reset_i,
  output logic [SLOT_W-1:0] wb_slot_o,
  output logic              wb_boot_o,
  output logic              soc_rst_no,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, SETUP_CYCLES, BOOT_CYCLES, TIMEOUT_CYCLES);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] wb_slot_q, wb_slot_d;
  logic              wb_boot_q, wb_boot_d;
  logic              soc_rst_n_q, soc_rst_n_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic              pin_pulse_c, pin_next_c;
  logic              pin_acc_c, sw_acc_c, cnt_zero_c;
  logic [SLOT_W-1:0] req_slot_c;

  wbctrl_pin_sync
`ifdef WBCTRL_PIN_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
  u_pin_sync (
    .clk_i        (clk_i),
    .rst_n        (rst_in),
    .pin_i        (pin_req_i),
    .pulse_c      (pin_pulse_c),
    .pulse_next_c (pin_next_c)
  );

  // Next state and next registered outputs; outputs follow the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_slot_d  = wb_slot_q;
    err_d      = err_q;
    pin_acc_c  = (state_q == IDLE) && pin_pulse_c;
    sw_acc_c   = sw_req_valid_i && ready_q && !pin_acc_c;
    req_slot_c = pin_acc_c ? pin_slot_i : sw_req_slot_i;
    cnt_zero_c = (cnt_q == '0);

    case (state_q)
      IDLE: begin
        if (pin_acc_c || sw_acc_c) begin
          if (32'(req_slot_c) < NUM_SLOTS) begin
            err_d     = 1'b0;
            wb_slot_d = req_slot_c;
            state_d   = HOLD;
            cnt_d     = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_zero_c) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETUP: begin
        if (cnt_zero_c) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(BOOT_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_zero_c) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT: begin
        // Still here after the timeout: the fabric never reconfigured.
        if (cnt_zero_c) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wb_boot_d   = (state_d == PULSE);
    busy_d      = (state_d != IDLE);
    soc_rst_n_d = (state_d == IDLE) && !wb_reset_i;
    ready_d     = (state_d == IDLE) && !pin_next_c;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wb_slot_q   <= '0;
      wb_boot_q   <= 1'b0;
      soc_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_slot_q   <= wb_slot_d;
      wb_boot_q   <= wb_boot_d;
      soc_rst_n_q <= soc_rst_n_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  assign sw_req_ready_o = ready_q;
  assign wb_slot_o      = wb_slot_q;
  assign wb_boot_o      = wb_boot_q;
  assign soc_rst_no     = soc_rst_n_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed bench for warmboot_ctrl: a timeline model of the boot sequence is
// checked against the DUT every cycle, plus hand-computed literal checkpoints.
module tb_warmboot_ctrl;

  localparam int SLOT_W    = 4;
  localparam int NUM_SLOTS = 4;
  localparam int H         = 16;
  localparam int S         = 4;
  localparam int B         = 8;
  localparam int TO        = 1024;
  localparam int TOTAL     = H + S + B + TO;
`ifdef WBCTRL_PIN_DEBOUNCE_EN
  localparam int DEB = 256;
`else
  localparam int DEB = 0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_in = 1'b1;
  logic              pin_req_i = 1'b0;
  logic [SLOT_W-1:0] pin_slot_i = 4'd1;
  logic              sw_req_valid_i = 1'b0;
  logic [SLOT_W-1:0] sw_req_slot_i = 4'd0;
  logic              sw_req_ready_o;
  logic              wb_reset_i = 1'b0;
  logic [SLOT_W-1:0] wb_slot_o;
  logic              wb_boot_o;
  logic              soc_rst_no;
  logic              busy_o;
  logic              err_o;

  int n_checks = 0;
  int n_fail   = 0;

  warmboot_ctrl dut (
    .clk_i          (clk_i),
    .rst_in         (rst_in),
    .pin_req_i      (pin_req_i),
    .pin_slot_i     (pin_slot_i),
    .sw_req_valid_i (sw_req_valid_i),
    .sw_req_slot_i  (sw_req_slot_i),
    .sw_req_ready_o (sw_req_ready_o),
    .wb_reset_i     (wb_reset_i),
    .wb_slot_o      (wb_slot_o),
    .wb_boot_o      (wb_boot_o),
    .soc_rst_no     (soc_rst_no),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is a timeline measured in edges from its accept edge.
  bit          m_busy = 0, m_err = 0, m_ready = 0, m_boot = 0, m_soc = 0;
  logic [3:0]  m_slot = '0;
  int          ec = 0, start = 0;
  int          r0 = 0, r1 = 0, r2 = 0;  // pin high run-length ending at samples k, k-1, k-2

  initial forever begin
    bit fire, acc;
    int sl;
    @(posedge clk_i or negedge rst_in);
    if (!rst_in) begin
      m_busy = 0; m_err = 0; m_ready = 0; m_boot = 0; m_soc = 0; m_slot = '0;
      r0 = 0; r1 = 0; r2 = 0;
    end else begin
      ec++;
      fire = (r1 == DEB + 1);
      acc  = 0;
      sl   = 0;
      if (!m_busy) begin
        if (fire) begin
          acc = 1; sl = int'(pin_slot_i);
        end else if (sw_req_valid_i && m_ready) begin
          acc = 1; sl = int'(sw_req_slot_i);
        end
        if (acc) begin
          if (sl < NUM_SLOTS) begin
            m_busy = 1; start = ec; m_slot = 4'(sl); m_err = 0;
          end else begin
            m_err = 1;
          end
        end
      end else if (ec - start == TOTAL) begin
        m_busy = 0; m_err = 1;
      end
      r2 = r1;
      r1 = r0;
      r0 = pin_req_i ? ((r0 < DEB + 2) ? r0 + 1 : r0) : 0;
      m_ready = !m_busy && !(r1 == DEB + 1);
      m_boot  = m_busy && (ec - start >= H + S) && (ec - start < H + S + B);
      m_soc   = !m_busy && !wb_reset_i;
    end
  end

  initial forever begin
    @(negedge clk_i);
    chk("busy",    32'(busy_o),         32'(m_busy));
    chk("boot",    32'(wb_boot_o),      32'(m_boot));
    chk("soc_rst", 32'(soc_rst_no),     32'(m_soc));
    chk("err",     32'(err_o),          32'(m_err));
    chk("ready",   32'(sw_req_ready_o), 32'(m_ready));
    chk("slot",    32'(wb_slot_o),      32'(m_slot));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_boot, boot_cnt, got;
    bit seen;

    #1 rst_in = 1'b0;
    #2;
    chk("rst_busy",  32'(busy_o),         0);
    chk("rst_boot",  32'(wb_boot_o),      0);
    chk("rst_soc",   32'(soc_rst_no),     0);
    chk("rst_err",   32'(err_o),          0);
    chk("rst_ready", 32'(sw_req_ready_o), 0);
    chk("rst_slot",  32'(wb_slot_o),      0);
    repeat (3) @(negedge clk_i);
    #2 rst_in = 1'b1;
    @(negedge clk_i);
    chk("soc_up_after_reset", 32'(soc_rst_no), 1);

    // Slot 2: boot first high 20 edges after accept (cycle T+21), timeout at edge T+1052.
    sw_req_valid_i = 1'b1; sw_req_slot_i = 4'd2;
    chk("ready_idle", 32'(sw_req_ready_o), 1);
    @(negedge clk_i);
    sw_req_valid_i = 1'b0;
    chk("t1_busy", 32'(busy_o), 1);
    chk("t1_soc",  32'(soc_rst_no), 0);
    chk("t1_slot", 32'(wb_slot_o), 2);
    first_boot = -1; boot_cnt = 0;
    for (int j = 1; j <= TOTAL; j++) begin
      @(negedge clk_i);
      if (wb_boot_o === 1'b1) begin
        if (first_boot < 0) first_boot = j;
        boot_cnt++;
      end
      if (j == TOTAL - 1) chk("t1_err_before_to", 32'(err_o), 0);
    end
    chk("t1_first_boot", 32'(first_boot), 20);
    chk("t1_boot_len",   32'(boot_cnt),   8);
    chk("t1_err_to",     32'(err_o),      1);
    chk("t1_soc_to",     32'(soc_rst_no), 1);

    // Invalid slot 5, then a valid request clears err.
    sw_req_valid_i = 1'b1; sw_req_slot_i = 4'd5;
    @(negedge clk_i);
    sw_req_valid_i = 1'b0;
    chk("t2_err",  32'(err_o), 1);
    chk("t2_busy", 32'(busy_o), 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0 || wb_boot_o !== 1'b0) seen = 1;
    end
    chk("t2_no_seq", 32'(seen), 0);
    sw_req_valid_i = 1'b1; sw_req_slot_i = 4'd1;
    @(negedge clk_i);
    sw_req_valid_i = 1'b0;
    chk("t2_err_clr", 32'(err_o), 0);
    chk("t2_slot",    32'(wb_slot_o), 1);

    // Request during PULSE waits until the sequence returns to IDLE.
    repeat (21) @(negedge clk_i);
    chk("t4_in_pulse", 32'(wb_boot_o), 1);
    sw_req_valid_i = 1'b1; sw_req_slot_i = 4'd3;
    got = 0;
    for (int i = 0; i < 1100 && got == 0; i++) begin
      @(negedge clk_i);
      if (sw_req_ready_o === 1'b1) got = 1;
    end
    chk("t4_ready_after_seq", 32'(got), 1);
    @(negedge clk_i);
    sw_req_valid_i = 1'b0;
    chk("t4_busy", 32'(busy_o), 1);
    chk("t4_slot", 32'(wb_slot_o), 3);

    // Async reset in PULSE.
    repeat (21) @(negedge clk_i);
    chk("t5_in_pulse", 32'(wb_boot_o), 1);
    #2 rst_in = 1'b0;
    #1;
    chk("t5_boot_drop", 32'(wb_boot_o), 0);
    chk("t5_soc_low",   32'(soc_rst_no), 0);
    chk("t5_busy_low",  32'(busy_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_in = 1'b1;
    @(negedge clk_i);
    chk("t5_soc_up",  32'(soc_rst_no), 1);
    chk("t5_idle",    32'(busy_o), 0);
    chk("t5_ready",   32'(sw_req_ready_o), 1);

    // wb_reset_i holds the SoC in reset; a request is still accepted.
    wb_reset_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("t6_soc_held", 32'(soc_rst_no), 0);
    end
    sw_req_valid_i = 1'b1; sw_req_slot_i = 4'd0;
    @(negedge clk_i);
    sw_req_valid_i = 1'b0;
    wb_reset_i = 1'b0;
    chk("t6_accept", 32'(busy_o), 1);
    got = 0;
    for (int i = 0; i < 1100 && got == 0; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) got = 1;
    end
    chk("t6_seq_end", 32'(got), 1);
    chk("t6_soc_up",  32'(soc_rst_no), 1);

`ifndef WBCTRL_PIN_DEBOUNCE_EN
    // Pin slot 1 and software slot 3 collide on the pin's accept edge.
    pin_slot_i = 4'd1;
    pin_req_i  = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    sw_req_valid_i = 1'b1; sw_req_slot_i = 4'd3;
    chk("t3_ready_blocked", 32'(sw_req_ready_o), 0);
    @(negedge clk_i);
    sw_req_valid_i = 1'b0;
    chk("t3_busy", 32'(busy_o), 1);
    chk("t3_slot", 32'(wb_slot_o), 1);
    pin_req_i = 1'b0;
    got = 0;
    for (int i = 0; i < 1100 && got == 0; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) got = 1;
    end
    chk("t3_seq_end", 32'(got), 1);
`else
    // A 10-cycle pin glitch is shorter than the debounce window.
    pin_req_i = 1'b1;
    repeat (10) @(negedge clk_i);
    pin_req_i = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0) seen = 1;
    end
    chk("t7_glitch_ignored", 32'(seen), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/warmboot_ctrl.md
# warmboot_ctrl

Sequencer that owns the fabric's warm-boot primitive and the soft SoC's reset. Arbitrates reconfiguration requests from an external boot pin and from SoC software, then runs a fixed sequence: hold SoC in reset, present the slot, pulse BOOT, and supervise with a timeout. Sits in the user design between the WARMBOOT wrapper and the fsoc instance, replacing the hard-tied SLOT/BOOT constants.

## Interface
- SLOT_W, 4: width of the slot number.
- NUM_SLOTS, 4: slots 0..NUM_SLOTS-1 are valid; others are rejected.
- HOLD_CYCLES, 16: SoC reset held before the slot is driven.
- SETUP_CYCLES, 4: slot stable before BOOT rises.
- BOOT_CYCLES, 8: BOOT pulse width.
- TIMEOUT_CYCLES, 1024: wait after the pulse before declaring failure.
- DEBOUNCE_CYCLES, 256: pin stability window (only with the macro).

Ports:
- clk_i  in  1  single clock.
- rst_in  in  1  asynchronous, active-low reset.
- pin_req_i  in  1  asynchronous external boot request; rising edge triggers.
- pin_slot_i  in  SLOT_W  strapped slot for pin requests (quasi-static).
- sw_req_valid_i  in  1  software request valid.
- sw_req_slot_i  in  SLOT_W  software requested slot.
- sw_req_ready_o  out  1  software request accepted when valid & ready.
- wb_reset_i  in  1  RESET output of the warm-boot primitive, active-high.
- wb_slot_o  out  SLOT_W  to primitive SLOT.
- wb_boot_o  out  1  to primitive BOOT.
- soc_rst_no  out  1  active-low reset to the SoC.
- busy_o  out  1  sequence in progress (state != IDLE).
- err_o  out  1  sticky: invalid slot or timeout.

## Operation
- States: IDLE → HOLD → SETUP → PULSE → WAIT → IDLE. Each non-IDLE state uses one shared down-counter loaded on entry.
- IDLE: sw_req_ready_o = 1 unless a pin edge is detected in the same cycle. The pin has priority, and the software request is not accepted that cycle.
- Acceptance latches the slot. If the slot is < NUM_SLOTS: clear err_o, go to HOLD. Otherwise set err_o and stay in IDLE; no outputs change.
- HOLD: soc_rst_no = 0 and wb_slot_o is driven with the latched slot. Lasts HOLD_CYCLES.
- SETUP: as HOLD, wb_boot_o = 0. Lasts SETUP_CYCLES.
- PULSE: wb_boot_o = 1. Lasts BOOT_CYCLES.
- WAIT: wb_boot_o = 0, soc_rst_no = 0. Normally the fabric reconfigures here. After TIMEOUT_CYCLES: set err_o, go to IDLE, release soc_rst_no.
- soc_rst_no = 0 whenever wb_reset_i = 1, in any state. Requests in IDLE are still accepted during wb_reset_i.
- Pin and software requests arriving while busy are ignored. Pin edges are not queued and sw_req_ready_o = 0.
- All outputs are registered.

## Timing
- Reset values (rst_in low): state IDLE, wb_slot_o 0, wb_boot_o 0, soc_rst_no 0, busy_o 0, err_o 0, sw_req_ready_o 0.
- soc_rst_no rises on the first clock edge after rst_in deasserts, provided wb_reset_i = 0.
- Software accept at edge T: busy_o = 1 and soc_rst_no = 0 from T+1, and wb_slot_o is valid from T+1.
- wb_boot_o is high for exactly BOOT_CYCLES, starting HOLD_CYCLES + SETUP_CYCLES after T+1.
- Pin path: 2-FF synchronizer, then edge detect. The request is accepted 3 edges after the pin rises.
- Asynchronous reset mid-sequence forces IDLE immediately and drops wb_boot_o.
- The counter width is clog2 of the largest cycle parameter. Every cycle parameter must be ≥ 1.

## Configuration
- WBCTRL_PIN_DEBOUNCE_EN defined: the synchronized pin must be stable high for DEBOUNCE_CYCLES before its edge is reported. Pin acceptance latency becomes 3 + DEBOUNCE_CYCLES edges. Any glitch restarts the window.
- Undefined: no debounce logic. The synchronized edge is used directly.

## Structure
- Package wbctrl_pkg holds:
  - the state enum (IDLE, HOLD, SETUP, PULSE, WAIT);
  - the default cycle constants;
  - a function that returns the counter width.
- Sub-module wbctrl_pin_sync contains the synchronizer, the optional debounce and the rising-edge detect, and outputs a one-cycle pulse.

## Test plan
- Software request, slot 2, defaults → ready high in IDLE. soc_rst_no falls at T+1. wb_slot_o = 2. wb_boot_o is high for 8 cycles starting at T+21. Timeout sets err_o at T+1053 and soc_rst_no rises.
- Software request, slot 5 (NUM_SLOTS = 4) → err_o = 1 the next cycle, busy_o stays 0, wb_boot_o never rises. A following valid request clears err_o.
- Pin edge and software valid in the same cycle (pin slot 1, software slot 3) → sw_req_ready_o = 0 that cycle and wb_slot_o = 1.
- Software request during PULSE → ready stays 0, the sequence is unaltered, and the request is accepted after returning to IDLE.
- rst_in pulsed low during PULSE → wb_boot_o = 0 and soc_rst_no = 0 immediately. After release: IDLE, soc_rst_no = 1 on the next edge.
- wb_reset_i = 1 in IDLE → soc_rst_no = 0 for its whole duration. With the macro defined, a 10-cycle pin glitch produces no request.
